pipeline_stall_ctrl: RTL and testbench
======================================

Name: pipeline_stall_ctrl

Overview:
- Central stall/flush scheduler for the 5-stage RV32I pipeline (IF/ID/EX/MA/WB).
- Decides each cycle which pipeline registers hold and which get a bubble. Causes: load-use hazards, taken branches/jumps resolved in EX, and instruction- or data-memory wait handshakes.
- Complements the EX-stage forwarding selector, which resolves every RAW hazard except a load followed immediately by its consumer.
- Keeps saturating performance counters for stall and flush cycles.

Parameters:
- CNT_W, 32, width of the stall_cnt and flush_cnt performance counters.
- MEM_TIMEOUT, 0, maximum cycles in MEM_WAIT before mem_err is set; 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- RS1_ID  in  5  rs1 of the instruction in ID.
- RS2_ID  in  5  rs2 of the instruction in ID.
- RS1used_ID  in  1  the ID instruction reads rs1.
- RS2used_ID  in  1  the ID instruction reads rs2.
- RD_EX  in  5  rd of the instruction in EX.
- MemRead_EX  in  1  the EX instruction is a load.
- BrTaken_EX  in  1  branch/jump in EX redirects the PC this cycle.
- imem_ready  in  1  instruction fetch completes this cycle.
- dmem_req_MA  in  1  MA stage is issuing a data access.
- dmem_ready  in  1  data access completes this cycle.
- stall_IF  out  1  hold the PC.
- stall_ID  out  1  hold the IF/ID register.
- stall_EX  out  1  hold the ID/EX register.
- stall_MA  out  1  hold the EX/MA register.
- flush_ID  out  1  load a bubble into IF/ID.
- flush_EX  out  1  load a bubble into ID/EX.
- flush_WB  out  1  load a bubble into MA/WB.
- state  out  2  current FSM state, for debug.
- stall_cnt  out  CNT_W  cycles with stall_IF=1, saturating.
- flush_cnt  out  CNT_W  cycles with flush_ID|flush_EX=1, saturating.
- mem_err  out  1  sticky data-memory timeout flag.

Behaviour:
- Reset (asynchronous, active-high):
  - state=RUN, both counters 0, mem_err 0, internal wait counter 0, redirect_pend 0.
  - All stall/flush outputs 0 while reset is high.
- Control outputs are combinational from state, registered flags and inputs. Counters and state update on the rising clk edge.
- Load-use condition (lu): MemRead_EX & RD_EX≠0 & ((RS1used_ID & RS1_ID==RD_EX) | (RS2used_ID & RS2_ID==RD_EX)). Register x0 never causes a hazard.
- States:
  - RUN (00).
  - MEM_WAIT (01).
  - REDIR (10): redirect pending while fetch is busy.
  - 11 is unused; if reached, the next state is RUN.
- Priority within a cycle, highest first:
  1. Data wait: dmem_req_MA & !dmem_ready.
  2. Branch redirect.
  3. Load-use.
  4. Fetch wait.
- RUN:
  - Data wait: stall_IF/ID/EX/MA=1, flush_WB=1, next state MEM_WAIT. BrTaken_EX is ignored this cycle; the branch stays held in EX and is seen again later.
  - Else if BrTaken_EX: flush_ID=1, flush_EX=1, no stalls.
    - If imem_ready=0 in the same cycle: stall_IF=1 and next state REDIR.
  - Else if lu: stall_IF=1, stall_ID=1, flush_EX=1 for exactly one cycle. The next cycle the load is in MA, lu is false and forwarding handles the value.
  - Else if imem_ready=0: stall_IF=1, flush_ID=1 (bubble into ID). Downstream stages advance.
- MEM_WAIT:
  - Same outputs as the RUN data-wait case while dmem_ready=0. The wait counter increments each cycle.
  - If MEM_TIMEOUT≠0 and the wait counter reaches MEM_TIMEOUT, mem_err is set (sticky until reset). Stalling continues regardless.
  - On dmem_ready=1: no stalls this cycle, the wait counter clears, next state RUN. If lu/BrTaken_EX are also active, they are serviced in this same cycle with RUN rules.
- REDIR:
  - flush_ID=1 and stall_IF=1 while imem_ready=0, so the wrong-path fetch is discarded.
  - On imem_ready=1: flush_ID=1, no stall, next state RUN.
  - If a data wait arises while in REDIR, it takes precedence (MEM_WAIT outputs apply) and the redirect is remembered in redirect_pend. MEM_WAIT then exits to REDIR instead of RUN.
- Counters:
  - stall_cnt increments on every cycle with stall_IF=1.
  - flush_cnt increments on every cycle with flush_ID|flush_EX=1.
  - Both saturate at all-ones and never wrap.
- Reset asserted mid-stall: outputs drop to 0 immediately (asynchronous). The pipeline restarts from the reset PC.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - state encodings ST_RUN=2'b00, ST_MEM_WAIT=2'b01, ST_REDIR=2'b10;
  - the constant REG_X0=5'd0.
- One sub-module, sat_counter (parameter W; inc input, count output, asynchronous active-high reset), instantiated twice for stall_cnt and flush_cnt.

Test Plan:
- Load-use: MemRead_EX=1, RD_EX=5, RS2_ID=5, RS2used_ID=1 for one cycle -> stall_IF=stall_ID=flush_EX=1 for exactly 1 cycle; stall_cnt 0→1.
- x0 load: MemRead_EX=1, RD_EX=0, RS1_ID=0, RS1used_ID=1 -> no stall, no flush; all counters stay 0.
- Branch: BrTaken_EX=1 with imem_ready=1 -> flush_ID=flush_EX=1 for 1 cycle, state stays RUN, flush_cnt=1. Repeat with imem_ready low for 3 cycles -> REDIR for 3 cycles, flush_ID high for 4 cycles total, flush_cnt=4.
- Data wait: dmem_req_MA=1, dmem_ready low for 4 cycles -> stall_IF..MA and flush_WB high for 4 cycles, state=01. On the ready cycle -> all low, state returns to 00; stall_cnt=4.
- Timeout: MEM_TIMEOUT=8, dmem_ready low for 20 cycles -> mem_err rises after 8 wait cycles and remains 1 after dmem_ready. Asserting reset mid-wait clears mem_err, state and counters immediately, without waiting for a clock edge.
- Saturation: CNT_W=4, stall_IF held via imem_ready=0 for 20 cycles -> stall_cnt stops at 15.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline stall/flush scheduler.
// The FSM states and the hard-wired zero register number live here.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_MEM_WAIT = 2'b01,
    ST_REDIR    = 2'b10,
    ST_UNUSED   = 2'b11
  } state_e;

  localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
// Used for the stall and flush performance counters.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (inc && (r_count != {W{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush scheduler for the 5-stage RV32I pipeline.
// Handles data-memory waits, EX-resolved redirects, load-use hazards and fetch waits.
module pipeline_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int          CNT_W       = 32,
  parameter int unsigned MEM_TIMEOUT = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       RS1_ID,
  input  logic [4:0]       RS2_ID,
  input  logic             RS1used_ID,
  input  logic             RS2used_ID,
  input  logic [4:0]       RD_EX,
  input  logic             MemRead_EX,
  input  logic             BrTaken_EX,
  input  logic             imem_ready,
  input  logic             dmem_req_MA,
  input  logic             dmem_ready,
  output logic             stall_IF,
  output logic             stall_ID,
  output logic             stall_EX,
  output logic             stall_MA,
  output logic             flush_ID,
  output logic             flush_EX,
  output logic             flush_WB,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             mem_err
);

  localparam logic [31:0] TIMEOUT_V = 32'(MEM_TIMEOUT);

  state_e      r_state;
  logic        r_redirPend;
  logic [31:0] r_waitCnt;
  logic        r_memErr;

  state_e      w_next;
  logic        w_lu;
  logic        w_dataWait;
  logic        w_setPend;
  logic        w_clrPend;
  logic        w_stallIF, w_stallID, w_stallEX, w_stallMA;
  logic        w_flushID, w_flushEX, w_flushWB;
  logic        w_waiting;
  logic [31:0] w_waitInc;

  assign w_lu = MemRead_EX && (RD_EX != REG_X0) &&
                ((RS1used_ID && (RS1_ID == RD_EX)) ||
                 (RS2used_ID && (RS2_ID == RD_EX)));
  assign w_dataWait = dmem_req_MA && !dmem_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_RUN;
      r_redirPend <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_setPend) begin
        r_redirPend <= 1'b1;
      end else if (w_clrPend) begin
        r_redirPend <= 1'b0;
      end
    end
  end

  // MEM_WAIT holds regardless of dmem_req_MA; only dmem_ready releases it.
  always_comb begin
    w_next    = r_state;
    w_setPend = 1'b0;
    w_clrPend = 1'b0;
    w_stallIF = 1'b0;
    w_stallID = 1'b0;
    w_stallEX = 1'b0;
    w_stallMA = 1'b0;
    w_flushID = 1'b0;
    w_flushEX = 1'b0;
    w_flushWB = 1'b0;
    if ((r_state == ST_MEM_WAIT) && !dmem_ready) begin
      {w_stallIF, w_stallID, w_stallEX, w_stallMA, w_flushWB} = 5'b11111;
      w_next = ST_MEM_WAIT;
    end else if ((r_state == ST_MEM_WAIT) && r_redirPend) begin
      w_flushID = 1'b1;
      w_clrPend = 1'b1;
      w_next    = ST_REDIR;
    end else if (r_state == ST_REDIR) begin
      if (w_dataWait) begin
        {w_stallIF, w_stallID, w_stallEX, w_stallMA, w_flushWB} = 5'b11111;
        w_setPend = 1'b1;
        w_next    = ST_MEM_WAIT;
      end else begin
        w_flushID = 1'b1;
        if (!imem_ready) begin
          w_stallIF = 1'b1;
        end else begin
          w_next = ST_RUN;
        end
      end
    end else if ((r_state == ST_RUN) || (r_state == ST_MEM_WAIT)) begin
      w_next = ST_RUN;
      if (w_dataWait) begin
        {w_stallIF, w_stallID, w_stallEX, w_stallMA, w_flushWB} = 5'b11111;
        w_next = ST_MEM_WAIT;
      end else if (BrTaken_EX) begin
        w_flushID = 1'b1;
        w_flushEX = 1'b1;
        if (!imem_ready) begin
          w_stallIF = 1'b1;
          w_next    = ST_REDIR;
        end
      end else if (w_lu) begin
        w_stallIF = 1'b1;
        w_stallID = 1'b1;
        w_flushEX = 1'b1;
      end else if (!imem_ready) begin
        w_stallIF = 1'b1;
        w_flushID = 1'b1;
      end
    end else begin
      w_next = ST_RUN;
    end
  end

  assign w_waiting = (r_state == ST_MEM_WAIT) && !dmem_ready;
  assign w_waitInc = (r_waitCnt == 32'hFFFF_FFFF) ? r_waitCnt : r_waitCnt + 32'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_waitCnt <= '0;
      r_memErr  <= 1'b0;
    end else begin
      if (w_waiting) begin
        r_waitCnt <= w_waitInc;
        if ((TIMEOUT_V != 32'd0) && (w_waitInc >= TIMEOUT_V)) begin
          r_memErr <= 1'b1;
        end
      end else if (r_state == ST_MEM_WAIT) begin
        r_waitCnt <= '0;
      end
    end
  end

  // Reset forces every control output low without waiting for a clock edge.
  assign stall_IF = w_stallIF && !reset;
  assign stall_ID = w_stallID && !reset;
  assign stall_EX = w_stallEX && !reset;
  assign stall_MA = w_stallMA && !reset;
  assign flush_ID = w_flushID && !reset;
  assign flush_EX = w_flushEX && !reset;
  assign flush_WB = w_flushWB && !reset;
  assign state    = r_state;
  assign mem_err  = r_memErr;

  sat_counter #(.W(CNT_W)) u_stallCnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_IF),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flushCnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flush_ID || flush_EX),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed self-checking bench for pipeline_stall_ctrl (CNT_W=4, MEM_TIMEOUT=8).
// Control outputs are compared as {stall_IF,ID,EX,MA, flush_ID,EX,WB}.
module tb_pipeline_stall_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic [4:0] RS1_ID, RS2_ID, RD_EX;
  logic       RS1used_ID, RS2used_ID, MemRead_EX, BrTaken_EX;
  logic       imem_ready, dmem_req_MA, dmem_ready;
  logic       stall_IF, stall_ID, stall_EX, stall_MA;
  logic       flush_ID, flush_EX, flush_WB;
  logic [1:0] state;
  logic [3:0] stall_cnt, flush_cnt;
  logic       mem_err;

  int compareCnt  = 0;
  int mismatchCnt = 0;

  pipeline_stall_ctrl #(.CNT_W(4), .MEM_TIMEOUT(8)) dut (
    .clk         (clock),
    .reset       (reset),
    .RS1_ID      (RS1_ID),
    .RS2_ID      (RS2_ID),
    .RS1used_ID  (RS1used_ID),
    .RS2used_ID  (RS2used_ID),
    .RD_EX       (RD_EX),
    .MemRead_EX  (MemRead_EX),
    .BrTaken_EX  (BrTaken_EX),
    .imem_ready  (imem_ready),
    .dmem_req_MA (dmem_req_MA),
    .dmem_ready  (dmem_ready),
    .stall_IF    (stall_IF),
    .stall_ID    (stall_ID),
    .stall_EX    (stall_EX),
    .stall_MA    (stall_MA),
    .flush_ID    (flush_ID),
    .flush_EX    (flush_EX),
    .flush_WB    (flush_WB),
    .state       (state),
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt),
    .mem_err     (mem_err)
  );

  always #5 clock = ~clock;

  localparam logic [6:0] C_IDLE  = 7'b0000000;
  localparam logic [6:0] C_LU    = 7'b1100010;
  localparam logic [6:0] C_BR    = 7'b0000110;
  localparam logic [6:0] C_BRW   = 7'b1000110;
  localparam logic [6:0] C_FWAIT = 7'b1000100;
  localparam logic [6:0] C_REDOK = 7'b0000100;
  localparam logic [6:0] C_DWAIT = 7'b1111001;

  function automatic logic [31:0] ctrlVec();
    return {25'd0, stall_IF, stall_ID, stall_EX, stall_MA, flush_ID, flush_EX, flush_WB};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCnt++;
    if (observed !== expected) begin
      mismatchCnt++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Inputs change just after the falling edge; outputs are sampled 1ns later.
  task automatic applyStimulus(input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic r1u, input logic r2u, input logic [4:0] rd,
                               input logic memRd, input logic br, input logic imemRdy,
                               input logic dReq, input logic dRdy);
    RS1_ID = rs1; RS2_ID = rs2; RS1used_ID = r1u; RS2used_ID = r2u;
    RD_EX = rd; MemRead_EX = memRd; BrTaken_EX = br;
    imem_ready = imemRdy; dmem_req_MA = dReq; dmem_ready = dRdy;
    #1;
  endtask

  task automatic idle();
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic doReset();
    @(negedge clock);
    reset = 1'b1;
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("rst_ctrl_gated", ctrlVec(), 32'(C_IDLE));
    reset = 1'b0;
    idle();
  endtask

  initial begin
    reset = 1'b1;
    doReset();
    checkOutput("rst_state", 32'(state), 32'd0);
    checkOutput("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    checkOutput("rst_flush_cnt", 32'(flush_cnt), 32'd0);
    checkOutput("rst_mem_err", 32'(mem_err), 32'd0);
    checkOutput("rst_ctrl", ctrlVec(), 32'(C_IDLE));

    // Load-use on rs2, then a non-matching pair, then load-use beating a fetch wait
    applyStimulus(5'd1, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("lu_ctrl", ctrlVec(), 32'(C_LU));
    tick();
    idle();
    checkOutput("lu_release", ctrlVec(), 32'(C_IDLE));
    checkOutput("lu_stall_cnt", 32'(stall_cnt), 32'd1);
    checkOutput("lu_flush_cnt", 32'(flush_cnt), 32'd1);
    applyStimulus(5'd5, 5'd6, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("lu_unused_rs1", ctrlVec(), 32'(C_IDLE));
    applyStimulus(5'd7, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("lu_over_fetch", ctrlVec(), 32'(C_LU));
    tick();
    idle();
    checkOutput("lu2_stall_cnt", 32'(stall_cnt), 32'd2);

    // Load to x0 never stalls
    doReset();
    applyStimulus(5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("x0_ctrl", ctrlVec(), 32'(C_IDLE));
    tick();
    idle();
    checkOutput("x0_stall_cnt", 32'(stall_cnt), 32'd0);
    checkOutput("x0_flush_cnt", 32'(flush_cnt), 32'd0);

    // Taken branch with fetch ready
    doReset();
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("br_ctrl", ctrlVec(), 32'(C_BR));
    tick();
    idle();
    checkOutput("br_state", 32'(state), 32'd0);
    checkOutput("br_flush_cnt", 32'(flush_cnt), 32'd1);
    checkOutput("br_stall_cnt", 32'(stall_cnt), 32'd0);

    // Taken branch with fetch busy for 3 cycles
    doReset();
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("brw_ctrl", ctrlVec(), 32'(C_BRW));
    tick();
    for (int i = 0; i < 2; i++) begin
      applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("redir_state", 32'(state), 32'd2);
      checkOutput("redir_ctrl", ctrlVec(), 32'(C_FWAIT));
      tick();
    end
    idle();
    checkOutput("redir_last_state", 32'(state), 32'd2);
    checkOutput("redir_last_ctrl", ctrlVec(), 32'(C_REDOK));
    tick();
    checkOutput("redir_exit_state", 32'(state), 32'd0);
    checkOutput("redir_flush_cnt", 32'(flush_cnt), 32'd4);
    checkOutput("redir_stall_cnt", 32'(stall_cnt), 32'd3);

    // Data wait for 4 cycles; a concurrent branch on entry is ignored
    doReset();
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("dw_entry_ctrl", ctrlVec(), 32'(C_DWAIT));
    tick();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      checkOutput("dw_state", 32'(state), 32'd1);
      checkOutput("dw_ctrl", ctrlVec(), 32'(C_DWAIT));
      tick();
    end
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    checkOutput("dw_ready_ctrl", ctrlVec(), 32'(C_IDLE));
    tick();
    idle();
    checkOutput("dw_exit_state", 32'(state), 32'd0);
    checkOutput("dw_stall_cnt", 32'(stall_cnt), 32'd4);
    checkOutput("dw_flush_cnt", 32'(flush_cnt), 32'd0);
    checkOutput("dw_mem_err", 32'(mem_err), 32'd0);

    // Data wait during REDIR returns to REDIR afterwards
    doReset();
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("rdw_ctrl", ctrlVec(), 32'(C_DWAIT));
    tick();
    checkOutput("rdw_state", 32'(state), 32'd1);
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    checkOutput("rdw_back_redir", 32'(state), 32'd2);
    idle();
    tick();
    checkOutput("rdw_run", 32'(state), 32'd0);

    // Timeout: dmem_ready low for 20 cycles
    doReset();
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) tick();
    checkOutput("to_err_before", 32'(mem_err), 32'd0);
    tick();
    checkOutput("to_err_set", 32'(mem_err), 32'd1);
    for (int i = 0; i < 11; i++) tick();
    checkOutput("to_still_wait", 32'(state), 32'd1);
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    tick();
    idle();
    checkOutput("to_exit_state", 32'(state), 32'd0);
    checkOutput("to_err_sticky", 32'(mem_err), 32'd1);
    checkOutput("to_stall_sat", 32'(stall_cnt), 32'd15);

    // Asynchronous reset in the middle of a wait
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    tick();
    #1;
    reset = 1'b1;
    #1;
    checkOutput("arst_state", 32'(state), 32'd0);
    checkOutput("arst_mem_err", 32'(mem_err), 32'd0);
    checkOutput("arst_stall_cnt", 32'(stall_cnt), 32'd0);
    checkOutput("arst_ctrl", ctrlVec(), 32'(C_IDLE));
    @(negedge clock);
    reset = 1'b0;
    idle();

    // Saturation: fetch wait for 20 cycles
    doReset();
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("sat_ctrl", ctrlVec(), 32'(C_FWAIT));
    for (int i = 0; i < 14; i++) tick();
    checkOutput("sat_cnt14", 32'(stall_cnt), 32'd14);
    for (int i = 0; i < 6; i++) tick();
    idle();
    checkOutput("sat_stall_cnt", 32'(stall_cnt), 32'd15);
    checkOutput("sat_flush_cnt", 32'(flush_cnt), 32'd15);
    checkOutput("sat_state", 32'(state), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCnt, mismatchCnt);
    $finish;
  end

endmodule
